// File: rtl/adc_offset_cal_ctrl_if.sv
// Sample/result/calibration bundle for the ADC offset calibration controller.
// The master drives samples and calibration requests; the slave is the controller.
interface adc_offset_cal_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              calStart;
    logic              sampleValid;
    logic [DATA_W-1:0] sampleData;
    logic [DATA_W-1:0] dataOutput;
    logic              outValid;
    logic [DATA_W-1:0] offset;
    logic              calBusy;
    logic              calDone;

    modport master (
        output calStart, sampleValid, sampleData,
        input  dataOutput, outValid, offset, calBusy, calDone
    );

    modport slave (
        input  calStart, sampleValid, sampleData,
        output dataOutput, outValid, offset, calBusy, calDone
    );
endinterface

// File: rtl/adc_offset_cal_ctrl.sv
// ADC DC-offset removal: continuous offset subtraction plus a settle/average
// calibration sequence that reloads the offset register.
//
// state  | meaning
// IDLE   | waiting for calStart
// SETTLE | discarding SETTLE_N valid samples
// ACCUM  | summing 2^AVG_LOG2 valid samples
// APPLY  | loading rounded mean into offset, calDone high
module adc_offset_cal_ctrl #(
    parameter int DATA_W         = 16,
    parameter int DEFAULT_OFFSET = 450,
    parameter int SETTLE_N       = 8,
    parameter int AVG_LOG2       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_offset_cal_ctrl_if.slave cal_if
);
    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int AVG_N   = 2 ** AVG_LOG2;
    localparam int CNT_MAX = (SETTLE_N > AVG_N) ? SETTLE_N : AVG_N;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_N - 1);
    localparam logic [CNT_W-1:0]  AVG_LOAD    = CNT_W'(AVG_N - 1);
    localparam logic [ACC_W-1:0]  ROUND_HALF  = ACC_W'(1) << (AVG_LOG2 - 1);
    localparam logic [DATA_W-1:0] OFFSET_RST  = DATA_W'(DEFAULT_OFFSET);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_APPLY  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_offset;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_data_out;
    logic              r_out_valid;

    logic              w_sample;
    logic              w_cnt_tc;
    logic [DATA_W-1:0] w_new_offset;

    assign w_sample = cal_if.sampleValid;
    assign w_cnt_tc = (r_cnt == '0);

    // Carry past ACC_W only affects bits above DATA_W after the shift, so the
    // ACC_W-wide sum is enough before truncation.
    assign w_new_offset = DATA_W'((r_acc + ROUND_HALF) >> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_offset <= OFFSET_RST;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cal_if.calStart) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= SETTLE_LOAD;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (w_sample) begin
                        if (w_cnt_tc) begin
                            r_state <= S_ACCUM;
                            r_cnt   <= AVG_LOAD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_sample) begin
                        r_acc <= r_acc + ACC_W'(cal_if.sampleData);
                        if (w_cnt_tc) begin
                            r_state <= S_APPLY;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_APPLY: begin
                    r_offset <= w_new_offset;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Offset subtraction runs in every state with the offset held at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_sample;
            if (w_sample) begin
                r_data_out <= cal_if.sampleData - r_offset;
            end
        end
    end

    assign cal_if.dataOutput = r_data_out;
    assign cal_if.outValid   = r_out_valid;
    assign cal_if.offset     = r_offset;
    assign cal_if.calBusy    = r_busy;
    assign cal_if.calDone    = r_done;
endmodule

// File: tb/tb_adc_offset_cal_ctrl.sv
// Directed bench for adc_offset_cal_ctrl: a count-based calibration model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_adc_offset_cal_ctrl;
    localparam int SETTLE_N = 8;
    localparam int AVG_N    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    adc_offset_cal_ctrl_if #(.DATA_W(16)) u_if ();

    adc_offset_cal_ctrl #(
        .DATA_W(16), .DEFAULT_OFFSET(450), .SETTLE_N(SETTLE_N), .AVG_LOG2(4)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .cal_if (u_if)
    );

    always #5 clk = ~clk;

    // Model: after calStart, the first SETTLE_N valid samples are dropped, the
    // next AVG_N are summed, and the rounded mean becomes the offset one cycle
    // after the last sample is taken.
    logic [15:0] m_offset, m_data;
    logic        m_valid, m_busy, m_done, m_apply;
    int          m_n, m_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_offset = 16'd450; m_data = '0; m_valid = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_apply = 1'b0; m_n = 0; m_sum = 0;
        end else begin
            m_valid = u_if.sampleValid;
            if (u_if.sampleValid) m_data = u_if.sampleData - m_offset;
            m_done = 1'b0;
            if (m_apply) begin
                m_offset = 16'((m_sum + AVG_N / 2) / AVG_N);
                m_apply  = 1'b0;
                m_busy   = 1'b0;
            end else if (m_busy) begin
                if (u_if.sampleValid) begin
                    m_n++;
                    if (m_n > SETTLE_N) m_sum += int'(u_if.sampleData);
                    if (m_n == SETTLE_N + AVG_N) begin
                        m_apply = 1'b1;
                        m_done  = 1'b1;
                    end
                end
            end else if (u_if.calStart) begin
                m_busy = 1'b1;
                m_n    = 0;
                m_sum  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_dataOutput", 32'(u_if.dataOutput), 32'(m_data));
            chk("model_outValid",   32'(u_if.outValid),   32'(m_valid));
            chk("model_offset",     32'(u_if.offset),     32'(m_offset));
            chk("model_calBusy",    32'(u_if.calBusy),    32'(m_busy));
            chk("model_calDone",    32'(u_if.calDone),    32'(m_done));
            if (u_if.calDone) done_cnt++;
        end
    end

    task automatic cyc(input logic cs, input logic v, input logic [15:0] d);
        u_if.calStart    = cs;
        u_if.sampleValid = v;
        u_if.sampleData  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cal(input logic [15:0] settle_val, input logic [15:0] acc_val);
        cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < SETTLE_N; i++) cyc(1'b0, 1'b1, settle_val);
        for (int i = 0; i < AVG_N; i++) cyc(1'b0, 1'b1, acc_val);
        cyc(1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 16'd0);
    endtask

    int done_before;

    initial begin
        u_if.calStart = 1'b0; u_if.sampleValid = 1'b0; u_if.sampleData = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_offset",   32'(u_if.offset),     32'd450);
        chk("rst_outValid", 32'(u_if.outValid),   32'd0);
        chk("rst_data",     32'(u_if.dataOutput), 32'd0);
        chk("rst_busy",     32'(u_if.calBusy),    32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'd0);

        // 1: subtraction around the default offset
        cyc(1'b0, 1'b1, 16'd450); chk("t1_450",   32'(u_if.dataOutput), 32'h0000);
        chk("t1_valid", 32'(u_if.outValid), 32'd1);
        cyc(1'b0, 1'b1, 16'd451); chk("t1_451",   32'(u_if.dataOutput), 32'h0001);
        cyc(1'b0, 1'b1, 16'd449); chk("t1_449",   32'(u_if.dataOutput), 32'hFFFF);

        // 2: wrap-around and hold
        cyc(1'b0, 1'b1, 16'd0);      chk("t2_zero", 32'(u_if.dataOutput), 32'hFE3E);
        cyc(1'b0, 1'b1, 16'hFFFF);   chk("t2_max",  32'(u_if.dataOutput), 32'hFE3D);
        cyc(1'b0, 1'b0, 16'd1234);   chk("t2_hold", 32'(u_if.dataOutput), 32'hFE3D);
        chk("t2_novalid", 32'(u_if.outValid), 32'd0);

        // 3: full calibration to 500
        done_before = done_cnt;
        chk("t3_busy_pre", 32'(u_if.calBusy), 32'd0);
        cyc(1'b1, 1'b0, 16'd0);      chk("t3_busy_rise", 32'(u_if.calBusy), 32'd1);
        for (int i = 0; i < SETTLE_N; i++) cyc(1'b0, 1'b1, 16'd0);
        cyc(1'b0, 1'b1, 16'd500);    chk("t3_old_off", 32'(u_if.dataOutput), 32'h0032);
        for (int i = 1; i < AVG_N; i++) cyc(1'b0, 1'b1, 16'd500);
        chk("t3_done",      32'(u_if.calDone), 32'd1);
        chk("t3_busy_done", 32'(u_if.calBusy), 32'd1);
        cyc(1'b0, 1'b0, 16'd0);
        chk("t3_offset",    32'(u_if.offset),  32'd500);
        chk("t3_busy_fall", 32'(u_if.calBusy), 32'd0);
        chk("t3_done_fall", 32'(u_if.calDone), 32'd0);
        cyc(1'b0, 1'b1, 16'd500);    chk("t3_new_off", 32'(u_if.dataOutput), 32'h0000);
        chk("t3_done_once", 32'(done_cnt - done_before), 32'd1);

        // 4: rounding with gap cycles
        cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < SETTLE_N; i++) cyc(1'b0, 1'b1, 16'd7);
        for (int i = 0; i < AVG_N; i++) begin
            cyc(1'b0, 1'b1, (i < 8) ? 16'd100 : 16'd101);
            if (i < AVG_N - 1) cyc(1'b0, 1'b0, 16'd0);
        end
        chk("t4_done", 32'(u_if.calDone), 32'd1);
        cyc(1'b0, 1'b0, 16'd0);
        chk("t4_offset", 32'(u_if.offset), 32'd101);

        // 5a: calStart during ACCUM is ignored
        done_before = done_cnt;
        cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < SETTLE_N; i++) cyc(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'd200);
        cyc(1'b1, 1'b1, 16'd200);
        for (int i = 6; i < AVG_N; i++) cyc(1'b0, 1'b1, 16'd200);
        cyc(1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 16'd0);
        chk("t5_offset", 32'(u_if.offset), 32'd200);
        chk("t5_done_once", 32'(done_cnt - done_before), 32'd1);

        // 5b: reset mid-ACCUM, then a clean calibration
        cyc(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < SETTLE_N; i++) cyc(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'd900);
        u_if.sampleValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_offset", 32'(u_if.offset),  32'd450);
        chk("t5_rst_busy",   32'(u_if.calBusy), 32'd0);
        chk("t5_rst_done",   32'(u_if.calDone), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0, 16'd0);
        run_cal(16'd0, 16'd300);
        chk("t5_recal", 32'(u_if.offset), 32'd300);

        // 6: sample coincident with calStart is not a settling sample
        cyc(1'b1, 1'b1, 16'd9999);
        chk("t6_busy", 32'(u_if.calBusy), 32'd1);
        for (int i = 0; i < SETTLE_N; i++) cyc(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < AVG_N; i++) cyc(1'b0, 1'b1, 16'd500);
        cyc(1'b0, 1'b0, 16'd0);
        chk("t6_offset", 32'(u_if.offset), 32'd500);
        cyc(1'b0, 1'b0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
